product_bcd_scan: RTL
=====================

# product_bcd_scan

Downstream display stage for the sequential 8x8 multiplier. It captures the 16-bit product whenever the multiplier's done flag rises and converts it to five BCD digits with a serial shift-add-3 (double-dabble) engine. It then drives a time-multiplexed five-digit seven-segment display with optional leading-zero blanking.

## Interface
Parameters:
- SCAN_W, 10: refresh counter width; each digit is lit for 2^SCAN_W cycles.
- BLANK_LZ, 1: 1 blanks leading zeros (digit 0 is never blanked); 0 shows all digits.

Ports:
- clk  in  1  system clock, rising edge.
- reset_a  in  1  reset, synchronous and active-low.
- product_in  in  16  multiplier product (product8x8_out).
- done_flag  in  1  multiplier completion flag; level or pulse.
- busy  out  1  high while a conversion is in progress.
- bcd_valid  out  1  high once bcd_out holds a completed conversion.
- bcd_out  out  20  five BCD digits; [19:16] is digit 4 (MSD), [3:0] is digit 0.
- dig_en  out  5  one-hot digit enable, active-high; bit i selects digit i.
- seg_a..seg_g  out  1 each  segments of the selected digit, active-high.

## Operation
- done_flag is registered into done_q. A capture event is done_flag=1 and done_q=0, sampled at a rising edge.
- FSM has two states, IDLE and CONV.
- IDLE:
  - On a capture event: load shift register {20'b0, product_in}, clear iteration counter, busy<=1, bcd_valid<=0, go to CONV.
  - Otherwise hold.
- CONV, once per cycle:
  - Each 4-bit BCD field ≥5 gets +3 (all fields in parallel, from current values).
  - Then the whole 36-bit register shifts left by 1.
  - Counter increments.
- After the 16th shift: bcd_out<=upper 20 bits, busy<=0, bcd_valid<=1, go to IDLE.
- Capture events during CONV are ignored and not queued. done_q still tracks done_flag, so a flag held high does not retrigger.
- bcd_out keeps the previous result during CONV. The display never shows partial values.
- Range: the maximum product, 65025, fits in five digits. No overflow handling is needed.
- Scanner:
  - A free-running SCAN_W-bit counter advances digit index idx (0→1→2→3→4→0) on each wrap.
  - dig_en = one-hot(idx).
  - Segments decode bcd_out nibble idx; nibbles above 9 decode to all segments off.
- Blanking: with BLANK_LZ=1, digit idx>0 is all-off when digits idx..4 are all zero.
- Segment encoding: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.

## Timing
- Reset (reset_a=0 at a rising edge) forces:
  - state=IDLE, done_q=0, busy=0, bcd_valid=0, bcd_out=0;
  - scan counter=0, idx=0, dig_en=5'b00001;
  - segments show "0": a..f=1, g=0.
- Reset mid-conversion aborts the conversion and leaves no partial result.
- Because done_q resets to 0, a done_flag held high through reset release produces a capture on the first active cycle.
- Latency, with the capture at edge E0:
  - busy is high after E0.
  - Shifts occur at E1..E16.
  - bcd_out, bcd_valid=1 and busy=0 all take effect at E16.
  - The next capture is accepted from E17 onward.
- Segment outputs are combinational from registered bcd_out and idx only. They are glitch-free relative to clk and never depend on inputs directly.
- The scan period is 5·2^SCAN_W cycles. idx wraps from 4 to 0 with no dead cycle.

## Structure
Shared package mult_disp_pkg holds:
- the BCD digit count (5);
- the conversion cycle count (16);
- the FSM state encoding (IDLE, CONV);
- the seven-segment pattern constants for digits 0–9 and BLANK.

One sub-module, seg7_decode: a combinational 4-bit BCD plus blank input to seg_a..seg_g. It is reusable by the multiplier's own display path.

## Test plan
- 11×85: product_in=935, done_flag rises. At E16: bcd_out=20'h00935, bcd_valid=1, busy=0. Digit 0 shows acdfg ("5"), digit 1 abcdg ("3"), digit 2 abcdfg ("9"). Digits 3 and 4 are all-off.
- Maximum: product_in=65025 gives bcd_out=20'h65025 after exactly 16 cycles. All five digits are lit.
- Zero: product_in=0 gives bcd_out=0. Only digit 0 shows "0". With BLANK_LZ=0, all five digits show "0".
- Ignored retrigger: a second done_flag edge at E5 with product_in=100 leaves the first result unaltered at E16. A fresh edge after E17 converts 100 → 20'h00100.
- Reset mid-conversion: reset_a=0 at E8 gives busy=0, bcd_valid=0, bcd_out=0 and dig_en=00001 on the next cycle. No result appears at E16.
- Scan with SCAN_W=2: dig_en steps 00001→00010→00100→01000→10000→00001, each step held for 4 cycles.

Source files
------------

// File: rtl/mult_disp_pkg.sv
`default_nettype none
// ============================================================================
// mult_disp_pkg : shared constants for the 8x8 multiplier display path
// Rev 1.0
// ============================================================================
package mult_disp_pkg;

  localparam int BCD_DIGITS  = 5;
  localparam int CONV_CYCLES = 16;
  localparam int PROD_W      = 16;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int SHIFT_W     = BCD_W + PROD_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  // Segment patterns packed as {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : combinational BCD digit to active-high seven-segment drive
// Rev 1.0
// ============================================================================
module seg7_decode
  import mult_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic       seg_a,
  output logic       seg_b,
  output logic       seg_c,
  output logic       seg_d,
  output logic       seg_e,
  output logic       seg_f,
  output logic       seg_g
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (!blank) begin
      pat = seg_pattern(digit);
    end
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = pat;

endmodule
`default_nettype wire

// File: rtl/product_bcd_scan.sv
`default_nettype none
// ============================================================================
// product_bcd_scan : captures the multiplier product, converts it to BCD with
// a serial double-dabble engine and scans a five-digit 7-segment display.
// Rev 1.0
// ============================================================================
module product_bcd_scan
  import mult_disp_pkg::*;
#(
  parameter int SCAN_W   = 10,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                reset_a,
  input  logic [PROD_W-1:0]   product_in,
  input  logic                done_flag,
  output logic                busy,
  output logic                bcd_valid,
  output logic [BCD_W-1:0]    bcd_out,
  output logic [4:0]          dig_en,
  output logic                seg_a,
  output logic                seg_b,
  output logic                seg_c,
  output logic                seg_d,
  output logic                seg_e,
  output logic                seg_f,
  output logic                seg_g
);

  conv_state_t          state, state_nxt;
  logic                 done_q;
  logic [SHIFT_W-1:0]   sh, sh_nxt, adj;
  logic [3:0]           cnt, cnt_nxt;
  logic                 busy_nxt, valid_nxt;
  logic [BCD_W-1:0]     bcd_nxt;
  logic                 capture;

  logic [SCAN_W-1:0]    scan_cnt;
  logic [2:0]           idx;
  logic [3:0]           cur_digit;
  logic [BCD_W-1:0]     upper;
  logic                 blank;

  assign capture = done_flag && !done_q;

  always_comb begin
    adj = sh;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sh[PROD_W + 4*i +: 4] >= 4'd5) begin
        adj[PROD_W + 4*i +: 4] = sh[PROD_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    valid_nxt = bcd_valid;
    bcd_nxt   = bcd_out;
    case (state)
      ST_IDLE: begin
        if (capture) begin
          sh_nxt    = {{BCD_W{1'b0}}, product_in};
          cnt_nxt   = 4'd0;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        sh_nxt  = adj << 1;
        cnt_nxt = cnt + 4'd1;
        // Last shift: publish the result in the same edge as the final shift
        if (cnt == 4'(CONV_CYCLES - 1)) begin
          bcd_nxt   = sh_nxt[SHIFT_W-1:PROD_W];
          busy_nxt  = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_a) begin
      state     <= ST_IDLE;
      done_q    <= 1'b0;
      sh        <= '0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_out   <= '0;
    end else begin
      state     <= state_nxt;
      done_q    <= done_flag;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      bcd_valid <= valid_nxt;
      bcd_out   <= bcd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_a) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  assign dig_en = 5'b00001 << idx;

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      3'd0:    cur_digit = bcd_out[3:0];
      3'd1:    cur_digit = bcd_out[7:4];
      3'd2:    cur_digit = bcd_out[11:8];
      3'd3:    cur_digit = bcd_out[15:12];
      3'd4:    cur_digit = bcd_out[19:16];
      default: cur_digit = 4'd0;
    endcase
  end

  // A digit is leading-zero when it and every more significant digit are zero
  assign upper = bcd_out >> {idx, 2'b00};
  assign blank = (BLANK_LZ != 0) && (idx != 3'd0) && (upper == '0);

  seg7_decode u_seg7 (
    .digit (cur_digit),
    .blank (blank),
    .seg_a (seg_a),
    .seg_b (seg_b),
    .seg_c (seg_c),
    .seg_d (seg_d),
    .seg_e (seg_e),
    .seg_f (seg_f),
    .seg_g (seg_g)
  );

endmodule
`default_nettype wire
